thor2023_tlb_l1_ctrl: RTL and testbench
=======================================

# thor2023_tlb_l1_ctrl

Sequencer and arbiter for the write/maintenance port (port B) of the 64-entry × 128-bit L1 TLB RAM. It shares that port between three requesters: hardware fills from the L2 TLB/page walker, software TLB read/write (CSR path), and ASID/global invalidate sweeps. Port A stays with the lookup pipeline. The block selects the fill victim, organising the RAM as 16 sets × 4 ways.

## Interface
Parameters:
- AWID, 32, virtual address width
- PGBITS, 13, page offset bits; set index = vadr[PGBITS+3:PGBITS]

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- inv_req  in  1  invalidate request; hold until inv_ack
- inv_all  in  1  1 = invalidate all non-global entries, 0 = match inv_asid only
- inv_asid  in  12  ASID to invalidate
- inv_ack  out  1  one-cycle pulse when the sweep completes
- flushing  out  1  high during a sweep; the lookup side suppresses hits
- fill_req  in  1  fill request; hold until fill_ack
- fill_vadr  in  AWID  virtual address of the fill
- fill_entry  in  128  entry to write
- fill_ack  out  1  one-cycle pulse
- fill_idx  out  6  entry index written, valid with fill_ack
- sw_req  in  1  software access; hold until sw_ack
- sw_wr  in  1  1 = write, 0 = read
- sw_idx  in  6  entry index
- sw_din  in  128  write data
- sw_ack  out  1  one-cycle pulse
- sw_dout  out  128  read data, valid with sw_ack
- ram_en  out  1  port B enable
- ram_we  out  1  port B write enable
- ram_addr  out  6  port B address
- ram_din  out  128  port B write data
- ram_dout  in  128  port B read data, combinational (latency 0)

## Operation
- Entry format: V = bit 127, G = bit 126, ASID = bits [123:112].
- FSM states: IDLE, XFER, RACK, SWEEP.
- Arbitration in IDLE uses fixed priority: inv_req > fill_req > sw_req. A loser stays pending and is never dropped.
- Fill path:
  - Set is s = fill_vadr[PGBITS+3:PGBITS]; way is w = wayctr[s] (one 2-bit round-robin counter per set).
  - Index is {w,s}, meaning way in bits [5:4] and set in bits [3:0].
  - wayctr[s] increments (mod 4) when the fill is written.
- Software write: writes sw_din to sw_idx. Software read returns the entry at sw_idx. Software accesses do not touch wayctr.
- Sweep, per entry k = 0..63:
  - Clear V when V=1 && G=0 && (inv_all || ASID==inv_asid).
  - Otherwise leave the entry untouched (ram_we=0).
- Entries with G=1 are never cleared by a sweep.

## Timing
- Reset: state IDLE, all outputs 0, all wayctr 0, sweep counter 0.
- Request accepted in IDLE at cycle N. XFER is cycle N+1:
  - ram_en=1 and ram_addr/ram_din are driven from registers.
  - For writes, ram_we=1 and fill_ack or sw_ack pulses in N+1; fill_idx is valid in the same cycle.
  - For a software read, ram_we=0 and ram_dout is captured at the end of N+1. The FSM enters RACK, where sw_ack=1 and sw_dout is valid in N+2.
- Return to IDLE after XFER (write) or RACK (read). The requester deasserts its request on the cycle after ack, so a new grant is possible every 2 cycles (write) or 3 cycles (read).
- Sweep:
  - Entered from IDLE at cycle N. flushing=1 from N+1 through N+64 inclusive.
  - In cycle N+1+k, ram_addr=k and ram_en=1.
  - ram_we and ram_din (ram_dout with bit 127 cleared) are derived combinationally from ram_dout.
  - inv_ack pulses in N+65, with flushing=0 in that cycle; the FSM is in IDLE from N+66.
- Requests arriving during XFER, RACK or SWEEP wait. A fill and an invalidate in the same IDLE cycle: the invalidate goes first, and the fill is serviced after inv_ack.
- Sweep counter wraps 63→0 on exit and is reset to 0 on entry.
- wayctr wraps 3→0.
- rst mid-operation: return to IDLE immediately, abandon any sweep, emit no ack, and drive ram_we=0 in the cycle following the reset.

## Structure
- Shared package thor2023_tlb_pkg holds:
  - the field positions TLB_V=127, TLB_G=126, TLB_ASID_HI=123, TLB_ASID_LO=112;
  - the state enum;
  - the L1 constants (16 sets, 4 ways, 64 entries).
- No sub-module is needed. The round-robin counter array (16 × 2 bits) is inline.

## Test plan
- Fill: fill_vadr=0x0000_6000 (set 3) four times. Expected fill_idx = 0x03, 0x13, 0x23, 0x33, then 0x03 again on the 5th fill; each fill_ack comes 1 cycle after acceptance.
- Software: write sw_idx=10 with 0xC...0001, then read sw_idx=10. Expected sw_dout=0xC...0001, with sw_ack in the second cycle after acceptance.
- ASID sweep: load entries with ASID 5 (G=0), ASID 5 (G=1) and ASID 7; invalidate with asid=5, inv_all=0. Expected: only the G=0/ASID 5 entry has V cleared, flushing is high for exactly 64 cycles, and inv_ack arrives 65 cycles after acceptance.
- Simultaneous requests: inv_req and fill_req asserted in the same cycle. Expected: the sweep runs first, fill_ack comes after inv_ack, and the filled entry keeps V=1.
- Reset mid-sweep: rst at sweep entry 20. Expected: no inv_ack, entries 20..63 unchanged, and all outputs 0 in the cycle following the reset.
- Back-to-back software writes with sw_req held low for 1 cycle between them. Expected: every write is acked exactly once, with no double write.

Source files
------------

// File: rtl/thor2023_tlb_pkg.sv
// Shared definitions for the L1 TLB: entry field positions, geometry and
// controller state/operation encodings.
package thor2023_tlb_pkg;

  localparam int TLB_V       = 127;
  localparam int TLB_G       = 126;
  localparam int TLB_ASID_HI = 123;
  localparam int TLB_ASID_LO = 112;

  localparam int L1_SETS    = 16;
  localparam int L1_WAYS    = 4;
  localparam int L1_ENTRIES = 64;
  localparam int L1_SET_W   = 4;
  localparam int L1_WAY_W   = 2;

  typedef enum logic [1:0] {IDLE, XFER, RACK, SWEEP} tlb_state_e;

  // Operation latched at grant time; selects the ack and write behaviour
  typedef enum logic [1:0] {OP_FILL, OP_SWWR, OP_SWRD, OP_INV} tlb_op_e;

endpackage

// File: rtl/thor2023_tlb_l1_ctrl.sv
// Port-B sequencer/arbiter for the 64 x 128 L1 TLB RAM. Shares the port
// between hardware fills, software CSR access and invalidate sweeps, and
// picks fill victims round-robin per set (16 sets x 4 ways).
module thor2023_tlb_l1_ctrl
  import thor2023_tlb_pkg::*;
#(
  parameter int AWID   = 32,
  parameter int PGBITS = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inv_req,
  input  logic            inv_all,
  input  logic [11:0]     inv_asid,
  output logic            inv_ack,
  output logic            flushing,
  input  logic            fill_req,
  input  logic [AWID-1:0] fill_vadr,
  input  logic [127:0]    fill_entry,
  output logic            fill_ack,
  output logic [5:0]      fill_idx,
  input  logic            sw_req,
  input  logic            sw_wr,
  input  logic [5:0]      sw_idx,
  input  logic [127:0]    sw_din,
  output logic            sw_ack,
  output logic [127:0]    sw_dout,
  output logic            ram_en,
  output logic            ram_we,
  output logic [5:0]      ram_addr,
  output logic [127:0]    ram_din,
  input  logic [127:0]    ram_dout
);

  tlb_state_e           state, nstate;
  tlb_op_e              op_q;
  logic [L1_WAY_W-1:0]  wayctr [L1_SETS];
  logic [5:0]           swp_cnt;

  logic [5:0]           addr_p1;
  logic [127:0]         din_p1;
  logic                 inv_all_p1;
  logic [11:0]          inv_asid_p1;
  logic [127:0]         rd_p2;

  logic [L1_SET_W-1:0]  fill_set;
  logic                 sweep_clr;
  logic                 ram_we_c;
  logic                 unused_vadr;

  assign fill_set    = fill_vadr[PGBITS+3:PGBITS];
  assign unused_vadr = ^fill_vadr;

  // An entry is cleared by the sweep only if valid, non-global and matching
  assign sweep_clr = ram_dout[TLB_V] & ~ram_dout[TLB_G] &
                     (inv_all_p1 | (ram_dout[TLB_ASID_HI:TLB_ASID_LO] == inv_asid_p1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Control state: grant decode, victim counters, sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_FILL;
      swp_cnt <= '0;
      for (int i = 0; i < L1_SETS; i++) wayctr[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_req) begin
            op_q    <= OP_INV;
            swp_cnt <= '0;
          end else if (fill_req) begin
            op_q <= OP_FILL;
          end else if (sw_req) begin
            op_q <= sw_wr ? OP_SWWR : OP_SWRD;
          end
        end
        XFER: begin
          if (op_q == OP_FILL)
            wayctr[addr_p1[3:0]] <= addr_p1[5:4] + 2'd1;
        end
        SWEEP:   swp_cnt <= swp_cnt + 6'd1;
        default: ;
      endcase
    end
  end

  // Stage p1: address/data captured at grant; stage p2: read data captured in XFER
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (inv_req) begin
        inv_all_p1  <= inv_all;
        inv_asid_p1 <= inv_asid;
      end else if (fill_req) begin
        addr_p1 <= {wayctr[fill_set], fill_set};
        din_p1  <= fill_entry;
      end else if (sw_req) begin
        addr_p1 <= sw_idx;
        din_p1  <= sw_din;
      end
    end
    if (state == XFER) rd_p2 <= ram_dout;
  end

  // Next-state and output decode
  always_comb begin
    nstate   = state;
    inv_ack  = 1'b0;
    flushing = 1'b0;
    fill_ack = 1'b0;
    fill_idx = '0;
    sw_ack   = 1'b0;
    sw_dout  = '0;
    ram_en   = 1'b0;
    ram_we_c = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state)
      IDLE: begin
        if (inv_req)                 nstate = SWEEP;
        else if (fill_req || sw_req) nstate = XFER;
      end
      XFER: begin
        ram_en   = 1'b1;
        ram_we_c = (op_q != OP_SWRD);
        ram_addr = addr_p1;
        ram_din  = din_p1;
        if (op_q == OP_FILL) begin
          fill_ack = 1'b1;
          fill_idx = addr_p1;
        end
        sw_ack = (op_q == OP_SWWR);
        nstate = (op_q == OP_SWRD) ? RACK : IDLE;
      end
      RACK: begin
        if (op_q == OP_INV) begin
          inv_ack = 1'b1;
        end else begin
          sw_ack  = 1'b1;
          sw_dout = rd_p2;
        end
        nstate = IDLE;
      end
      SWEEP: begin
        flushing = 1'b1;
        ram_en   = 1'b1;
        ram_addr = swp_cnt;
        ram_we_c = sweep_clr;
        ram_din  = {1'b0, ram_dout[TLB_V-1:0]};
        if (swp_cnt == 6'd63) nstate = RACK;
      end
      default: nstate = IDLE;
    endcase
  end

  // A reset arriving mid-sweep abandons the entry under way as well
  assign ram_we = ram_we_c & ~rst;

endmodule

// File: tb/tb_thor2023_tlb_l1_ctrl.sv
// Directed bench for thor2023_tlb_l1_ctrl with a behavioural port-B RAM.
module tb_thor2023_tlb_l1_ctrl;

  logic         clk;
  logic         rst;
  logic         inv_req, inv_all, inv_ack, flushing;
  logic [11:0]  inv_asid;
  logic         fill_req, fill_ack;
  logic [31:0]  fill_vadr;
  logic [127:0] fill_entry;
  logic [5:0]   fill_idx;
  logic         sw_req, sw_wr, sw_ack;
  logic [5:0]   sw_idx;
  logic [127:0] sw_din, sw_dout;
  logic         ram_en, ram_we;
  logic [5:0]   ram_addr;
  logic [127:0] ram_din, ram_dout;

  logic [127:0] mem [64];
  logic         bd_we;
  logic [5:0]   bd_addr;
  logic [127:0] bd_data;
  int           wr_cnt = 0;

  int checks = 0;
  int errors = 0;

  thor2023_tlb_l1_ctrl #(.AWID(32), .PGBITS(13)) dut (
    .clk(clk), .rst(rst),
    .inv_req(inv_req), .inv_all(inv_all), .inv_asid(inv_asid),
    .inv_ack(inv_ack), .flushing(flushing),
    .fill_req(fill_req), .fill_vadr(fill_vadr), .fill_entry(fill_entry),
    .fill_ack(fill_ack), .fill_idx(fill_idx),
    .sw_req(sw_req), .sw_wr(sw_wr), .sw_idx(sw_idx), .sw_din(sw_din),
    .sw_ack(sw_ack), .sw_dout(sw_dout),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B RAM: combinational read, write on clock edge; backdoor for preload
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en && ram_we) mem[ram_addr] <= ram_din;
    if (ram_en && ram_we) wr_cnt <= wr_cnt + 1;
  end

  function automatic logic [127:0] ent(input logic [15:0] top, input int lo);
    return {top, 112'(lo)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [5:0] a, input logic [127:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic do_fill(input string tag, input logic [31:0] va,
                         input logic [127:0] e, input logic [5:0] exp_idx);
    fill_req = 1'b1; fill_vadr = va; fill_entry = e;
    tick();
    chk({tag, " ack"}, 128'(fill_ack), 128'd1);
    chk({tag, " idx"}, 128'(fill_idx), 128'(exp_idx));
    fill_req = 1'b0;
    tick();
    chk({tag, " ack low"}, 128'(fill_ack), 128'd0);
  endtask

  task automatic do_swwr(input string tag, input logic [5:0] idx, input logic [127:0] d);
    sw_req = 1'b1; sw_wr = 1'b1; sw_idx = idx; sw_din = d;
    tick();
    chk({tag, " ack"}, 128'(sw_ack), 128'd1);
    chk({tag, " we"}, 128'(ram_we), 128'd1);
    sw_req = 1'b0;
    tick();
  endtask

  // Runs an already-requested sweep from its first cycle to inv_ack
  task automatic sweep_wait(output int lat, output int nflush, output bit got);
    lat = 0; nflush = 0; got = 0;
    for (int c = 0; c < 100; c++) begin
      if (flushing) nflush++;
      if (inv_ack) begin
        got = 1; lat = c + 1;
        break;
      end
      tick();
    end
  endtask

  int  lat, nflush, acks, wr0;
  bit  got;

  initial begin
    rst = 1'b1;
    inv_req = 0; inv_all = 0; inv_asid = '0;
    fill_req = 0; fill_vadr = '0; fill_entry = '0;
    sw_req = 0; sw_wr = 0; sw_idx = '0; sw_din = '0;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    for (int k = 0; k < 64; k++) bd_write(6'(k), 128'd0);

    // Reset state
    chk("rst ram_en", 128'(ram_en), 128'd0);
    chk("rst ram_we", 128'(ram_we), 128'd0);
    chk("rst acks", 128'({inv_ack, fill_ack, sw_ack, flushing}), 128'd0);
    chk("rst ram_addr", 128'(ram_addr), 128'd0);
    rst = 1'b0;
    tick();

    // Fills to set 3 walk the ways round-robin
    do_fill("fill1", 32'h0000_6000, ent(16'h8000, 1), 6'h03);
    do_fill("fill2", 32'h0000_6000, ent(16'h8000, 2), 6'h13);
    do_fill("fill3", 32'h0000_6000, ent(16'h8000, 3), 6'h23);
    do_fill("fill4", 32'h0000_6000, ent(16'h8000, 4), 6'h33);
    do_fill("fill5", 32'h0000_6000, ent(16'h8000, 5), 6'h03);
    chk("fill mem13", mem[6'h13], ent(16'h8000, 2));
    chk("fill mem03", mem[6'h03], ent(16'h8000, 5));

    // Software write then read
    do_swwr("swwr10", 6'd10, ent(16'hC000, 1));
    sw_req = 1'b1; sw_wr = 1'b0; sw_idx = 6'd10;
    tick();
    chk("swrd xfer ack", 128'(sw_ack), 128'd0);
    chk("swrd xfer we", 128'(ram_we), 128'd0);
    chk("swrd xfer en", 128'(ram_en), 128'd1);
    tick();
    chk("swrd ack", 128'(sw_ack), 128'd1);
    chk("swrd dout", sw_dout, ent(16'hC000, 1));
    sw_req = 1'b0;
    tick();
    chk("swrd ack low", 128'(sw_ack), 128'd0);

    // ASID sweep
    do_swwr("ld40", 6'd40, ent(16'h8005, 'h40));
    do_swwr("ld41", 6'd41, ent(16'hC005, 'h41));
    do_swwr("ld42", 6'd42, ent(16'h8007, 'h42));
    inv_req = 1'b1; inv_all = 1'b0; inv_asid = 12'd5;
    tick();
    chk("sweep first addr", 128'(ram_addr), 128'd0);
    sweep_wait(lat, nflush, got);
    chk("sweep got ack", 128'(got), 128'd1);
    chk("sweep ack latency", 128'(lat), 128'd65);
    chk("sweep flush cycles", 128'(nflush), 128'd64);
    chk("sweep flushing at ack", 128'(flushing), 128'd0);
    inv_req = 1'b0;
    tick();
    chk("sweep ack low", 128'(inv_ack), 128'd0);
    chk("sweep mem40", mem[40], ent(16'h0005, 'h40));
    chk("sweep mem41", mem[41], ent(16'hC005, 'h41));
    chk("sweep mem42", mem[42], ent(16'h8007, 'h42));
    chk("sweep mem03", mem[3], ent(16'h8000, 5));

    // Invalidate and fill together: sweep first, fill afterwards survives
    inv_req = 1'b1; inv_all = 1'b1; inv_asid = 12'd0;
    fill_req = 1'b1; fill_vadr = 32'h0000_6000; fill_entry = ent(16'h8000, 6);
    tick();
    chk("simul flushing", 128'(flushing), 128'd1);
    chk("simul no fill ack", 128'(fill_ack), 128'd0);
    sweep_wait(lat, nflush, got);
    chk("simul inv ack", 128'(got), 128'd1);
    chk("simul fill during sweep", 128'(fill_ack), 128'd0);
    inv_req = 1'b0;
    tick();
    chk("simul fill not yet", 128'(fill_ack), 128'd0);
    tick();
    chk("simul fill ack", 128'(fill_ack), 128'd1);
    chk("simul fill idx", 128'(fill_idx), 128'h13);
    fill_req = 1'b0;
    tick();
    chk("simul mem13", mem[6'h13], ent(16'h8000, 6));
    chk("simul mem03", mem[6'h03], ent(16'h0000, 5));
    chk("simul mem41", mem[41], ent(16'hC005, 'h41));
    chk("simul mem10", mem[10], ent(16'hC000, 1));
    chk("simul mem42", mem[42], ent(16'h0007, 'h42));

    // Reset in the middle of a sweep
    for (int k = 0; k < 64; k++) bd_write(6'(k), ent(16'h8009, k));
    inv_req = 1'b1; inv_all = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) tick();
    chk("rstsw addr20", 128'(ram_addr), 128'd20);
    rst = 1'b1;
    tick();
    chk("rstsw ram_we", 128'(ram_we), 128'd0);
    chk("rstsw ram_en", 128'(ram_en), 128'd0);
    chk("rstsw flags", 128'({inv_ack, fill_ack, sw_ack, flushing}), 128'd0);
    chk("rstsw ram_addr", 128'(ram_addr), 128'd0);
    rst = 1'b0; inv_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 70; c++) begin
      if (inv_ack) acks++;
      tick();
    end
    chk("rstsw no inv_ack", 128'(acks), 128'd0);
    chk("rstsw mem19", mem[19], ent(16'h0009, 19));
    chk("rstsw mem20", mem[20], ent(16'h8009, 20));
    chk("rstsw mem63", mem[63], ent(16'h8009, 63));
    do_fill("rstsw fill", 32'h0000_6000, ent(16'h8000, 7), 6'h03);

    // Back-to-back software writes, one idle-request cycle between
    wr0 = wr_cnt; acks = 0;
    for (int i = 0; i < 3; i++) begin
      sw_req = 1'b1; sw_wr = 1'b1; sw_idx = 6'(50 + i); sw_din = ent(16'h8001, 50 + i);
      if (sw_ack) acks++;
      tick();
      if (sw_ack) acks++;
      sw_req = 1'b0;
      tick();
      if (sw_ack) acks++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (sw_ack) acks++;
    end
    chk("b2b acks", 128'(acks), 128'd3);
    chk("b2b writes", 128'(wr_cnt - wr0), 128'd3);
    chk("b2b mem50", mem[50], ent(16'h8001, 50));
    chk("b2b mem52", mem[52], ent(16'h8001, 52));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
